// File: rtl/dcache_mem_subsystem.sv
// dcache_mem_subsystem: an 8-line direct-mapped, write-back, write-allocate
// byte cache in front of a 256-byte main memory with fixed block latency.
//
// Ports:
//   CLK        sole clock, rising edge
//   RESET      asynchronous, active-low reset
//   READ       CPU byte-read request
//   WRITE      CPU byte-write request (wins when READ is also high)
//   ADDRESS    byte address: tag[7:5], index[4:2], offset[1:0]
//   WRITEDATA  byte to store
//   READDATA   byte read (0x00 when there is no hit)
//   BUSYWAIT   high while the CPU must stall and hold its request

// Main memory: 64 blocks x 32 bits. A held strobe completes on its
// MEM_LATENCY-th cycle (done is high in that cycle); writes commit and
// read data is captured at that edge.
module dcache_main_mem #(
    parameter int MEM_LATENCY = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        rd,
    input  logic        wr,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    logic [31:0]   mem [64];
    logic [CW-1:0] cnt;
    logic          active;

    assign active = rd | wr;
    assign done   = active && (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            // Counter restarts at completion so back-to-back transfers
            // (write-back then fetch) each take the full latency.
            if (active) cnt <= done ? '0 : cnt + CW'(1);
            else        cnt <= '0;
            if (wr && done) mem[addr] <= wdata;
            if (rd && done) rdata <= mem[addr];
        end
    end
endmodule

module dcache_mem_subsystem #(
    parameter int MEM_LATENCY = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ,
    input  logic       WRITE,
    input  logic [7:0] ADDRESS,
    input  logic [7:0] WRITEDATA,
    output logic [7:0] READDATA,
    output logic       BUSYWAIT
);
    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [2:0]  tag;
        logic [31:0] data;
    } line_t;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

    state_t      state, next_state;
    line_t       lines [8];
    line_t       cur;
    logic [2:0]  tag, index;
    logic [1:0]  offset;
    logic        req, hit;
    logic [31:0] merged;

    logic        mem_read, mem_write, mem_done;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;

    assign tag    = ADDRESS[7:5];
    assign index  = ADDRESS[4:2];
    assign offset = ADDRESS[1:0];
    assign req    = READ | WRITE;
    assign cur    = lines[index];
    assign hit    = req && cur.valid && (cur.tag == tag);

    always_comb begin
        READDATA = 8'h00;
        merged   = cur.data;
        for (int k = 0; k < 4; k++) begin
            if (offset == 2'(k)) begin
                if (hit) READDATA = cur.data[8*k +: 8];
                merged[8*k +: 8] = WRITEDATA;
            end
        end
    end

    // Gated by RESET so the stall drops the moment reset asserts,
    // even if a request is still being held on the inputs.
    assign BUSYWAIT  = RESET && ((state != IDLE) || (req && !hit));

    assign mem_read  = (state == MEM_READ);
    assign mem_write = (state == WRITE_BACK);
    // Write-back targets the victim's own block; fetch targets the request.
    assign mem_addr  = mem_write ? {cur.tag, index} : {tag, index};

    dcache_main_mem #(.MEM_LATENCY(MEM_LATENCY)) u_mem (
        .CLK   (CLK),
        .RESET (RESET),
        .rd    (mem_read),
        .wr    (mem_write),
        .addr  (mem_addr),
        .wdata (cur.data),
        .rdata (mem_rdata),
        .done  (mem_done)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (req && !hit)
                            next_state = (cur.valid && cur.dirty) ? WRITE_BACK : MEM_READ;
            WRITE_BACK: if (mem_done) next_state = MEM_READ;
            MEM_READ:   if (mem_done) next_state = UPDATE;
            UPDATE:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 8; i++) lines[i] <= '0;
        end else if (state == UPDATE) begin
            lines[index] <= '{valid: 1'b1, dirty: 1'b0, tag: tag, data: mem_rdata};
        end else if (state == IDLE && WRITE && hit) begin
            lines[index] <= '{valid: 1'b1, dirty: 1'b1, tag: cur.tag, data: merged};
        end
    end
endmodule

// File: tb/tb_dcache_mem_subsystem.sv
// Bench for dcache_mem_subsystem: directed steps followed by random
// requests checked against a byte-level behavioural cache/memory model.
module tb_dcache_mem_subsystem;
    localparam int L = 5;

    logic       CLK, RESET, READ, WRITE, BUSYWAIT;
    logic [7:0] ADDRESS, WRITEDATA, READDATA;

    int checks = 0;
    int errors = 0;

    dcache_mem_subsystem #(.MEM_LATENCY(L)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: flat byte memory plus per-line tag/valid/dirty/bytes.
    logic [7:0] m_mem  [256];
    logic [7:0] m_data [8][4];
    logic [2:0] m_tag  [8];
    logic       m_val  [8];
    logic       m_dty  [8];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = 3'd0; m_val[i] = 1'b0; m_dty[i] = 1'b0;
            for (int k = 0; k < 4; k++) m_data[i][k] = 8'h00;
        end
    endtask

    task automatic model_apply(input logic rd, input logic wr, input logic [7:0] a,
                               input logic [7:0] wd, output int stall, output logic [7:0] rdat);
        int t, ix, of;
        t = int'(a[7:5]); ix = int'(a[4:2]); of = int'(a[1:0]);
        stall = 0; rdat = 8'h00;
        if (!(rd || wr)) return;
        if (!(m_val[ix] && m_tag[ix] == 3'(t))) begin
            if (m_val[ix] && m_dty[ix]) begin
                stall = 2 + 2 * L;
                for (int k = 0; k < 4; k++) m_mem[int'(m_tag[ix]) * 32 + ix * 4 + k] = m_data[ix][k];
            end else begin
                stall = 2 + L;
            end
            for (int k = 0; k < 4; k++) m_data[ix][k] = m_mem[t * 32 + ix * 4 + k];
            m_tag[ix] = 3'(t); m_val[ix] = 1'b1; m_dty[ix] = 1'b0;
        end
        rdat = m_data[ix][of];
        if (wr) begin
            m_data[ix][of] = wd;
            m_dty[ix] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge; returns just after a falling edge
    // with the request dropped. Stall = falling edges seen with BUSYWAIT high.
    task automatic run_req(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] wd, output int stall, output logic [7:0] rdat);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        stall = 0;
        #1;
        while (BUSYWAIT === 1'b1 && stall < 100) begin
            stall++;
            @(negedge CLK);
            #1;
        end
        rdat = READDATA;
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic step(input string tag, input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input int exp_stall, input logic [7:0] exp_rd,
                        input bit check_rd);
        int ms, st;
        logic [7:0] mr, rv;
        model_apply(rd, wr, a, wd, ms, mr);
        run_req(rd, wr, a, wd, st, rv);
        chk({tag, "_stall"}, 32'(st), 32'(exp_stall));
        if (check_rd) chk({tag, "_rdata"}, 32'(rv), 32'(exp_rd));
    endtask

    initial begin
        int ms, st, kind;
        logic [7:0] mr, rv, a, wd;
        logic rd, wr;

        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        model_reset();
        #2;
        chk("rst_busy", 32'(BUSYWAIT), 32'd0);
        chk("rst_rdata", 32'(READDATA), 32'h00);
        chk("rst_strobes", 32'({dut.mem_read, dut.mem_write}), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        step("cold_wr03",  1'b0, 1'b1, 8'h03, 8'h0A, 2 + L,     8'h00, 1'b0);
        step("rd03",       1'b1, 1'b0, 8'h03, 8'h00, 0,         8'h0A, 1'b1);
        step("wr02_hit",   1'b0, 1'b1, 8'h02, 8'hAA, 0,         8'h00, 1'b0);
        step("rd02",       1'b1, 1'b0, 8'h02, 8'h00, 0,         8'hAA, 1'b1);
        step("rd03_again", 1'b1, 1'b0, 8'h03, 8'h00, 0,         8'h0A, 1'b1);
        step("rd23_dirty", 1'b1, 1'b0, 8'h23, 8'h00, 2 + 2 * L, 8'h00, 1'b1);
        step("rd03_clean", 1'b1, 1'b0, 8'h03, 8'h00, 2 + L,     8'h0A, 1'b1);
        step("rd02_wb",    1'b1, 1'b0, 8'h02, 8'h00, 0,         8'hAA, 1'b1);
        // READ and WRITE together behave as a write: line becomes dirty.
        step("both_wr01",  1'b1, 1'b1, 8'h01, 8'h5C, 0,         8'h00, 1'b0);
        step("rd01",       1'b1, 1'b0, 8'h01, 8'h00, 0,         8'h5C, 1'b1);

        // Reset in the middle of a clean fetch.
        READ = 1'b1; ADDRESS = 8'h47;
        @(negedge CLK); @(negedge CLK);
        chk("pre_rst_mem_read", 32'(dut.mem_read), 32'd1);
        RESET = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSYWAIT), 32'd0);
        chk("abort_rdata", 32'(READDATA), 32'h00);
        chk("abort_strobes", 32'({dut.mem_read, dut.mem_write}), 32'd0);
        @(negedge CLK);
        READ = 1'b0;
        model_reset();
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle_busy", 32'(BUSYWAIT), 32'd0);
            chk("idle_strobes", 32'({dut.mem_read, dut.mem_write}), 32'd0);
            @(negedge CLK);
        end
        step("post_rst_rd03", 1'b1, 1'b0, 8'h03, 8'h00, 2 + L, 8'h00, 1'b1);
        step("post_rst_rd47", 1'b1, 1'b0, 8'h47, 8'h00, 2 + L, 8'h00, 1'b1);

        // Random traffic over a few tags and indices to force conflicts.
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            rd = (kind == 1) || (kind >= 2 && kind < 6);
            wr = (kind == 1) || (kind >= 6);
            a  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wd = 8'($urandom);
            model_apply(rd, wr, a, wd, ms, mr);
            run_req(rd, wr, a, wd, st, rv);
            chk("rnd_stall", 32'(st), 32'(ms));
            if (rd && !wr) chk("rnd_rdata", 32'(rv), 32'(mr));
        end

        // Sweep every byte the random phase could have touched.
        for (int t = 0; t < 4; t++)
            for (int ix = 0; ix < 4; ix++)
                for (int of = 0; of < 4; of++) begin
                    a = {3'(t), 3'(ix), 2'(of)};
                    model_apply(1'b1, 1'b0, a, 8'h00, ms, mr);
                    run_req(1'b1, 1'b0, a, 8'h00, st, rv);
                    chk("sweep_rdata", 32'(rv), 32'(mr));
                end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_mem_subsystem.md
DCACHE_MEM_SUBSYSTEM -- requirements
Module: dcache_mem_subsystem

Interface
REQ-001 SHALL provide parameter MEM_LATENCY, default 5, main-memory block-access time in clock cycles (minimum 1).
REQ-002 SHALL provide port CLK, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port RESET, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL provide port READ, input, 1, CPU byte-read request.
REQ-005 SHALL provide port WRITE, input, 1, CPU byte-write request.
REQ-006 SHALL provide port ADDRESS, input, 8, byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 SHALL provide port WRITEDATA, input, 8, byte to store.
REQ-008 SHALL provide port READDATA, output, 8, byte read.
REQ-009 SHALL provide port BUSYWAIT, output, 1, high = CPU must stall and hold its request stable.

Function
REQ-010 SHALL contain a 256-byte main memory organised as 64 blocks of 4 bytes, with a 6-bit block address and a 32-bit block port; byte k of a block occupies bits [8k+7:8k].
REQ-011 SHALL contain a direct-mapped, write-back, write-allocate cache: 8 lines, each 32-bit data, 3-bit tag, valid bit, dirty bit.
REQ-012 SHALL detect a hit when the request is active, line[index] is valid and the tags are equal; hit logic SHALL be combinational.
REQ-013 On a read hit, READDATA SHALL present byte[offset] combinationally with BUSYWAIT low in the same cycle.
REQ-014 On a write hit, BUSYWAIT SHALL stay low and, at the next rising edge, the byte SHALL be written and the dirty bit set.
REQ-015 On a miss, BUSYWAIT SHALL go high combinationally in the same cycle.
REQ-016 The FSM SHALL have states IDLE, WRITE_BACK, MEM_READ and UPDATE.
REQ-017 On a miss in IDLE with a valid, dirty victim, the FSM SHALL go to WRITE_BACK; otherwise it SHALL go to MEM_READ.
REQ-018 WRITE_BACK SHALL write the victim block to address {old tag, index} over MEM_LATENCY cycles, then go to MEM_READ.
REQ-019 MEM_READ SHALL fetch block {tag, index} over MEM_LATENCY cycles, then go to UPDATE.
REQ-020 UPDATE SHALL, in one cycle, load the data, set the tag, set valid and clear dirty, then go to IDLE.
REQ-021 Back in IDLE, the request SHALL be serviced as a hit per REQ-013/014.
REQ-022 BUSYWAIT SHALL stay high from the miss cycle until the hit cycle: 2+MEM_LATENCY cycles for a clean miss, 2+2*MEM_LATENCY cycles for a dirty miss.
REQ-023 Internal memory read/write strobes SHALL be asserted only in MEM_READ and WRITE_BACK respectively, never both at once.
REQ-024 The memory SHALL signal completion after exactly MEM_LATENCY cycles of a held strobe.
REQ-025 With READ and WRITE both high, the request SHALL be treated as a write.
REQ-026 With neither READ nor WRITE high, there SHALL be no state change and BUSYWAIT SHALL be low.
REQ-027 A request change while BUSYWAIT is high is a protocol violation; behaviour is undefined, but the FSM SHALL still return to IDLE.

Reset
REQ-028 While RESET is low, all valid and dirty bits and all tags SHALL be 0, the FSM SHALL be in IDLE, BUSYWAIT and the memory strobes SHALL be 0, READDATA SHALL be 0x00, and all 256 memory bytes SHALL be 0x00.
REQ-029 Reset asserted during WRITE_BACK or MEM_READ SHALL abort the transfer immediately; no partial cache line SHALL become valid.
REQ-030 After RESET deasserts, the first request SHALL be accepted at the next rising edge.

Verification
REQ-031 Cold write 0x0A to 0x03 -> BUSYWAIT high 7 cycles; then read 0x03 -> READDATA 0x0A, BUSYWAIT low, 0 stall cycles.
REQ-032 Write 0xAA to 0x02 (same line, hit) -> no stall; read 0x02 -> 0xAA; read 0x03 -> still 0x0A.
REQ-033 Read 0x23 (index 0, tag 1, dirty victim) -> stall 12 cycles; write-back puts 0x0A at memory byte 3 and 0xAA at byte 2; READDATA 0x00.
REQ-034 Read 0x03 again -> clean miss, stall 7 cycles, READDATA 0x0A.
REQ-035 Assert RESET low mid-MEM_READ -> BUSYWAIT 0 immediately; subsequent read of 0x03 misses and returns 0x00.
REQ-036 Hold READ=WRITE=0 for 10 cycles after reset -> BUSYWAIT 0 and no memory strobes throughout.
